d_fwd_hazard_unit: RTL

- Consumer end of the per-stage GRF write-data buses (E_GRF_Wdata, M_GRF_Wdata, W_GRF_Wdata) in the 5-stage pipelined MIPS core.
- Keeps a shadow pipeline of destination-register number and Tnew for the E, M and W stages, clocked in step with the real pipeline registers.
- Each cycle it decides whether the D-stage instruction must stall, or else which stage forwards its rs/rt operand values.
- Sits beside the D-stage GRF read ports and drives the F/D freeze and the D→E bubble.

---
 rtl/d_fwd_hazard_unit.sv | 94 +++++++++
 1 files changed

// File: rtl/d_fwd_hazard_unit.sv
// D-stage stall/forward decision for the 5-stage MIPS core, tracking E/M/W destination and Tnew.
// Optional stall_cnt output enabled by defining HAZARD_STALL_CNT_EN.
module d_fwd_hazard_unit #(
   parameter int unsigned TNEW_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        D_rs,
   input  logic [4:0]        D_rt,
   input  logic [TNEW_W-1:0] D_rs_tuse,
   input  logic [TNEW_W-1:0] D_rt_tuse,
   input  logic              D_rs_used,
   input  logic              D_rt_used,
   input  logic [4:0]        D_A3,
   input  logic [TNEW_W-1:0] D_tnew,
   input  logic [31:0]       D_rs_grf,
   input  logic [31:0]       D_rt_grf,
   input  logic [31:0]       E_GRF_Wdata,
   input  logic [31:0]       M_GRF_Wdata,
   input  logic [31:0]       W_GRF_Wdata,
   output logic              stall,
   output logic [31:0]       D_rs_fwd,
   output logic [31:0]       D_rt_fwd
`ifdef HAZARD_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   logic [4:0]        E_A3, M_A3, W_A3;
   logic [TNEW_W-1:0] E_tnew, M_tnew;
   logic              rs_hazard, rt_hazard;

   function automatic logic hazard(input logic [4:0] s, input logic used,
                                   input logic [TNEW_W-1:0] tuse);
      logic hit_e, hit_m;
      hit_e  = (s == E_A3) && (E_tnew > tuse);
      hit_m  = (s == M_A3) && (M_tnew > tuse);
      hazard = used && (s != 5'd0) && (hit_e || hit_m);
   endfunction

   // A younger match that is not ready yet shadows older stages and falls back to the GRF.
   function automatic logic [31:0] fwd(input logic [4:0] s, input logic [31:0] grf);
      if (s == 5'd0)
         fwd = '0;
      else if (s == E_A3)
         fwd = (E_tnew == '0) ? E_GRF_Wdata : grf;
      else if (s == M_A3)
         fwd = (M_tnew == '0) ? M_GRF_Wdata : grf;
      else if (s == W_A3)
         fwd = W_GRF_Wdata;
      else
         fwd = grf;
   endfunction

   always_comb begin
      rs_hazard = hazard(D_rs, D_rs_used, D_rs_tuse);
      rt_hazard = hazard(D_rt, D_rt_used, D_rt_tuse);
      stall     = rs_hazard || rt_hazard;
      D_rs_fwd  = fwd(D_rs, D_rs_grf);
      D_rt_fwd  = fwd(D_rt, D_rt_grf);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         E_A3   <= '0;
         E_tnew <= '0;
         M_A3   <= '0;
         M_tnew <= '0;
         W_A3   <= '0;
      end else begin
         if (stall) begin
            E_A3   <= '0;
            E_tnew <= '0;
         end else begin
            E_A3   <= D_A3;
            E_tnew <= D_tnew;
         end
         M_A3   <= E_A3;
         M_tnew <= (E_tnew == '0) ? '0 : E_tnew - TNEW_W'(1);
         W_A3   <= M_A3;
      end
   end

`ifdef HAZARD_STALL_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cnt <= '0;
      else if (stall)
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule
